// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, serial-subtractor state encoding
// and the signed-overflow helper.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Two's-complement overflow of a - b from the operand and result sign bits.
  function automatic logic sub_signed_ovf(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial a - b, LSB first, with start/busy/done handshake.
// Optional macro SUB_OVERFLOW_EN adds the registered signed-overflow output ovf.
module serial_subtractor_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_e       state_r;
  sub_state_e       next_state_s;
  logic             load_s;
  logic             finish_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-2:0] res_sr_r;
  logic [WIDTH-1:0] res_next_s;
  logic             bout_r;
  logic [CNT_W-1:0] count_r;
  logic             d_s;
  logic             bo_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;

  full_subtractor u_fs (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .bin  (bout_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // Newly produced bit enters at the top; the full word is complete on the last bit.
  assign res_next_s = {d_s, res_sr_r};
  assign finish_s   = (state_r == RUN) && (count_r == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a start in DONE reloads without an idle gap.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_BIT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand shift registers, partial result, running borrow and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_sr_r <= '0;
      bout_r   <= 1'b0;
      count_r  <= '0;
    end else if (load_s) begin
      a_sr_r   <= a_in;
      b_sr_r   <= b_in;
      res_sr_r <= '0;
      bout_r   <= 1'b0;
      count_r  <= '0;
    end else if (state_r == RUN) begin
      a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
      res_sr_r <= res_next_s[WIDTH-1:1];
      bout_r   <= bo_s;
      count_r  <= count_r + CNT_W'(1);
    end
  end

  // Handshake flags decoded from next state; result captured only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == RUN);
      done_r <= (next_state_s == DONE);
      if (finish_s) begin
        diff_r   <= res_next_s;
        borrow_r <= bo_s;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;

`ifdef SUB_OVERFLOW_EN
  logic a_msb_r;
  logic b_msb_r;
  logic ovf_r;

  // Operand sign bits are shifted away, so keep copies for the overflow check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (load_s) begin
        a_msb_r <= a_in[WIDTH-1];
        b_msb_r <= b_in[WIDTH-1];
      end
      if (finish_s) begin
        ovf_r <= sub_signed_ovf(a_msb_r, b_msb_r, d_s);
      end
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed bench for serial_subtractor_4bit; checks ovf when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int total;
  int bad;

  serial_subtractor_4bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is accepted on the next edge; operands are then scrambled.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
  endtask

  // Four RUN cycles; optionally pulse start with 1-1 in the second one.
  task automatic expect_run(input string tag, input bit poke);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
      chk({tag, "_done_low"}, {7'd0, done}, 8'd0);
      if (poke && i == 1) begin
        start = 1'b1;
        a_in  = 4'd1;
        b_in  = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [3:0] ed, input logic eb,
                             input logic eo);
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_busy_low"}, {7'd0, busy}, 8'd0);
    chk({tag, "_diff"}, {4'd0, diff}, {4'd0, ed});
    chk({tag, "_borrow"}, {7'd0, borrow}, {7'd0, eb});
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, {7'd0, ovf}, {7'd0, eo});
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf expectation for %s", tag);
`endif
  endtask

  task automatic expect_idle(input string tag, input logic [3:0] ed, input logic eb);
    start = 1'b0;
    tick();
    chk({tag, "_idle_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_hold_diff"}, {4'd0, diff}, {4'd0, ed});
    chk({tag, "_hold_borrow"}, {7'd0, borrow}, {7'd0, eb});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 4'd0;
    b_in  = 4'd0;
    #2;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_diff", {4'd0, diff}, 8'd0);
    chk("rst_borrow", {7'd0, borrow}, 8'd0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", {7'd0, ovf}, 8'd0);
`endif
    #10;
    rst_n = 1'b1;

    // 9 - 3 = 6; signed -7 - 3 overflows
    issue(4'd9, 4'd3);
    expect_run("op9m3", 1'b0);
    expect_done("op9m3", 4'd6, 1'b0, 1'b1);
    expect_idle("op9m3", 4'd6, 1'b0);

    // 3 - 9 wraps to 0xA with borrow; signed 3 - (-7) overflows
    issue(4'd3, 4'd9);
    expect_run("op3m9", 1'b0);
    expect_done("op3m9", 4'hA, 1'b1, 1'b1);
    expect_idle("op3m9", 4'hA, 1'b1);

    // 7 - (-1) = 8 overflows signed
    issue(4'd7, 4'hF);
    expect_run("op7mF", 1'b0);
    expect_done("op7mF", 4'h8, 1'b1, 1'b1);
    expect_idle("op7mF", 4'h8, 1'b1);

    // Equal operands
    issue(4'hC, 4'hC);
    expect_run("opCmC", 1'b0);
    expect_done("opCmC", 4'h0, 1'b0, 1'b0);
    expect_idle("opCmC", 4'h0, 1'b0);

    // Back-to-back: 5 - 2, then 0 - 1 issued during the DONE cycle
    issue(4'd5, 4'd2);
    expect_run("b2b_first", 1'b0);
    expect_done("b2b_first", 4'd3, 1'b0, 1'b0);
    issue(4'd0, 4'd1);
    expect_run("b2b_second", 1'b0);
    expect_done("b2b_second", 4'hF, 1'b1, 1'b0);
    expect_idle("b2b_second", 4'hF, 1'b1);

    // Start pulse with 1 - 1 during RUN of 8 - 0 must be ignored
    issue(4'd8, 4'd0);
    expect_run("ign", 1'b1);
    expect_done("ign", 4'd8, 1'b0, 1'b0);
    expect_idle("ign", 4'd8, 1'b0);
    tick();
    chk("ign_no_second_done", {7'd0, done}, 8'd0);
    chk("ign_no_restart", {7'd0, busy}, 8'd0);

    // Reset in the third RUN cycle of 9 - 3
    issue(4'd9, 4'd3);
    tick();
    tick();
    chk("abort_busy_before", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_diff", {4'd0, diff}, 8'd0);
    chk("abort_borrow", {7'd0, borrow}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", {7'd0, done}, 8'd0);
      chk("abort_stays_idle", {7'd0, busy}, 8'd0);
    end
    issue(4'd9, 4'd3);
    expect_run("after_abort", 1'b0);
    expect_done("after_abort", 4'd6, 1'b0, 1'b1);
    expect_idle("after_abort", 4'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
